// File: rtl/adder_xxbit_seq_ctrl_pkg.sv
// Shared definitions for the word-serial adder controller: FSM state
// encoding and the sizing helper for the word index counter.
package adder_pkg;

  // Controller states: waiting for a request, adding one word per cycle,
  // and presenting the finished sum until the consumer takes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/adder_xxbit_seq_ctrl_if.sv
// Request/result bundle of the word-serial adder controller.
// The slave side is the controller, the master side is whoever drives it.
interface adder_xxbit_seq_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_NUM   = 4
);

  // Request channel
  logic                             i_valid;
  logic                             o_ready;
  logic [DATA_WIDTH*WORD_NUM-1:0]   i_num_a;
  logic [DATA_WIDTH*WORD_NUM-1:0]   i_num_b;
  logic                             i_cry;

  // Result channel
  logic                             o_valid;
  logic                             i_ready;
  logic [DATA_WIDTH*WORD_NUM-1:0]   o_res;
  logic                             o_cry;

  // Status
  logic                             o_busy;

  modport slave (
    input  i_valid, i_num_a, i_num_b, i_cry, i_ready,
    output o_ready, o_valid, o_res, o_cry, o_busy
  );

  modport master (
    output i_valid, i_num_a, i_num_b, i_cry, i_ready,
    input  o_ready, o_valid, o_res, o_cry, o_busy
  );

endinterface

// File: rtl/adder_xxbit_seq_ctrl_serial.sv
// One-word adder used by the controller: a plain ripple-carry chain of
// full adders, DATA_WIDTH bits wide, with carry in and carry out.
module adder_xxbit_serial #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_cry,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_cry
);

  // carry_chain[gi] is the carry into bit gi
  logic [DATA_WIDTH:0] carry_chain;

  assign carry_chain[0] = i_cry;

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_fa
    logic half_sum;
    assign half_sum            = i_a[gi] ^ i_b[gi];
    assign o_res[gi]           = half_sum ^ carry_chain[gi];
    assign carry_chain[gi + 1] = (i_a[gi] & i_b[gi]) | (carry_chain[gi] & half_sum);
  end

  assign o_cry = carry_chain[DATA_WIDTH];

endmodule

// File: rtl/adder_xxbit_seq_ctrl.sv
// Word-serial wide adder controller. A request latches both operands and
// the carry-in, then one DATA_WIDTH slice is added per cycle through a
// single adder, least significant word first, with the carry rippled
// through a register between words. The full sum is held until accepted.
module adder_xxbit_seq_ctrl
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_NUM   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  adder_xxbit_seq_ctrl_if.slave  bus
);

  localparam int TOT_W = DATA_WIDTH * WORD_NUM;
  localparam int IDX_W = idx_width(WORD_NUM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_NUM - 1);

  // FSM
  state_t state_q, state_d;

  // Latched request
  logic [TOT_W-1:0] a_q, b_q;
  logic             cin_q;

  // Word sequencing and inter-word carry
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;

  // Result registers
  logic [TOT_W-1:0] res_q;
  logic             cry_q, cry_d;

  // Per-word views of the latched operands
  logic [DATA_WIDTH-1:0] a_words [WORD_NUM];
  logic [DATA_WIDTH-1:0] b_words [WORD_NUM];

  // Adder connections
  logic [DATA_WIDTH-1:0] add_a, add_b, add_sum;
  logic                  add_cin, add_cout;

  logic accept;    // request taken this edge
  logic step;      // one word is added this edge
  logic last_word; // current word is the most significant one

  assign accept    = (state_q == IDLE) && bus.i_valid;
  assign step      = (state_q == CALC);
  assign last_word = (idx_q == IDX_LAST);

  for (genvar gi = 0; gi < WORD_NUM; gi++) begin : g_words
    assign a_words[gi] = a_q[gi*DATA_WIDTH +: DATA_WIDTH];
    assign b_words[gi] = b_q[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // The first word takes the request carry, later words the rippled carry.
  assign add_a   = a_words[idx_q];
  assign add_b   = b_words[idx_q];
  assign add_cin = (idx_q == '0) ? cin_q : carry_q;

  adder_xxbit_serial #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_adder (
    .i_a   (add_a),
    .i_b   (add_b),
    .i_cry (add_cin),
    .o_res (add_sum),
    .o_cry (add_cout)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; handshake inputs only steer transitions
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_valid) state_d = CALC;
      CALC:    if (last_word)   state_d = DONE;
      DONE:    if (bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the index, the rippled carry and the final carry
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    cry_d   = cry_q;
    if (accept) begin
      idx_d = '0;
    end else if (step) begin
      carry_d = add_cout;
      // The index parks on the last word instead of wrapping.
      if (!last_word) begin
        idx_d = idx_q + 1'b1;
      end else begin
        cry_d = add_cout;
      end
    end
  end

  // Operand capture, only when a request is accepted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.i_num_a;
      b_q   <= bus.i_num_b;
      cin_q <= bus.i_cry;
    end
  end

  // Sequencing registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      cry_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cry_q   <= cry_d;
    end
  end

  // Each result word is overwritten only on the edge that computes it,
  // so the previous sum stays visible until the new one replaces it.
  for (genvar gi = 0; gi < WORD_NUM; gi++) begin : g_res
    logic word_we;
    assign word_we = step && (idx_q == IDX_W'(gi));

    // Result word register
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        res_q[gi*DATA_WIDTH +: DATA_WIDTH] <= '0;
      end else if (word_we) begin
        res_q[gi*DATA_WIDTH +: DATA_WIDTH] <= add_sum;
      end
    end
  end

  // Handshake outputs come from the state register alone.
  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_res   = res_q;
  assign bus.o_cry   = cry_q;

endmodule

// File: tb/tb_adder_xxbit_seq_ctrl.sv
// Directed and table-driven bench for the word-serial adder controller.
module tb_adder_xxbit_seq_ctrl;

  localparam int DW = 8;
  localparam int WN = 4;
  localparam int W  = DW * WN;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic         cry;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  adder_xxbit_seq_ctrl_if #(.DATA_WIDTH(DW), .WORD_NUM(WN)) bus ();

  adder_xxbit_seq_ctrl #(
    .DATA_WIDTH (DW),
    .WORD_NUM   (WN)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive a request at a falling edge; returns just after the accept edge.
  task automatic start_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    check("ready_before_req", 64'(bus.o_ready), 64'd1);
    bus.i_num_a = a;
    bus.i_num_b = b;
    bus.i_cry   = cin;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  // Count falling edges after acceptance until o_valid; optionally wiggle
  // the request inputs meanwhile. Ends at the falling edge with o_valid=1.
  task automatic wait_valid(input bit scramble, output int lat);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (scramble) begin
        bus.i_valid = 1'($urandom_range(0, 1));
        bus.i_num_a = $urandom;
        bus.i_num_b = $urandom;
        bus.i_cry   = 1'($urandom_range(0, 1));
      end
    end
    bus.i_valid = 1'b0;
    if (lat < 0) check("valid_timeout", 64'd0, 64'd1);
  endtask

  // Accept the result and confirm the return to IDLE one cycle later.
  task automatic release_txn();
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    check("idle_ready", 64'(bus.o_ready), 64'd1);
    check("idle_valid", 64'(bus.o_valid), 64'd0);
    check("idle_busy",  64'(bus.o_busy),  64'd0);
  endtask

  vec_t tbl [10];

  initial begin
    int lat;
    int last_cyc;
    logic [W:0] model;
    logic [W-1:0] ra, rb;
    logic rc;

    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    tbl[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0};
    tbl[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    tbl[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    tbl[5] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    tbl[6] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};
    tbl[7] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0};
    tbl[8] = '{32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 32'hDFD1_0456, 1'b0};
    tbl[9] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};

    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_num_a = '0;
    bus.i_num_b = '0;
    bus.i_cry   = 1'b0;

    // Reset state, observed before any clock edge
    #1;
    check("rst_ready", 64'(bus.o_ready), 64'd1);
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_busy",  64'(bus.o_busy),  64'd0);
    check("rst_res",   64'(bus.o_res),   64'd0);
    check("rst_cry",   64'(bus.o_cry),   64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      start_txn(tbl[i].a, tbl[i].b, tbl[i].cin);
      wait_valid(1'b0, lat);
      check("tbl_res",     64'(bus.o_res),  64'(tbl[i].res));
      check("tbl_cry",     64'(bus.o_cry),  64'(tbl[i].cry));
      check("tbl_latency", 64'(lat),        64'(WN));
      check("tbl_busy",    64'(bus.o_busy), 64'd1);
      check("tbl_ready",   64'(bus.o_ready), 64'd0);
      $display("vec %0d: a=%h b=%h cin=%0d -> res=%h cry=%0d lat=%0d",
               i, tbl[i].a, tbl[i].b, tbl[i].cin, bus.o_res, bus.o_cry, lat);
      release_txn();
    end

    // Result held for 5 cycles with i_ready low, then released
    start_txn(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);
    wait_valid(1'b0, lat);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", 64'(bus.o_valid), 64'd1);
      check("hold_ready", 64'(bus.o_ready), 64'd0);
      check("hold_res",   64'(bus.o_res),   64'h0000_0000);
      check("hold_cry",   64'(bus.o_cry),   64'd1);
      @(negedge clk);
    end
    $display("hold: res=%h cry=%0d held 5 cycles", bus.o_res, bus.o_cry);
    release_txn();
    check("idle_res_kept", 64'(bus.o_res), 64'h0000_0000);
    check("idle_cry_kept", 64'(bus.o_cry), 64'd1);

    // Request inputs wiggled during CALC must not disturb the result
    start_txn(32'h0102_0304, 32'h1020_3040, 1'b0);
    wait_valid(1'b1, lat);
    check("scr_res",     64'(bus.o_res), 64'h1122_3344);
    check("scr_cry",     64'(bus.o_cry), 64'd0);
    check("scr_latency", 64'(lat),       64'(WN));
    $display("scramble: res=%h cry=%0d lat=%0d", bus.o_res, bus.o_cry, lat);
    release_txn();

    // Asynchronous reset in the second CALC cycle
    start_txn(32'h1111_1111, 32'h2222_2222, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_res",   64'(bus.o_res),   64'd0);
    check("arst_cry",   64'(bus.o_cry),   64'd0);
    check("arst_valid", 64'(bus.o_valid), 64'd0);
    check("arst_busy",  64'(bus.o_busy),  64'd0);
    check("arst_ready", 64'(bus.o_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("arst_no_valid", 64'(bus.o_valid), 64'd0);
    end
    $display("reset abort: res=%h busy=%0d", bus.o_res, bus.o_busy);
    start_txn(32'h0000_0001, 32'h0000_0001, 1'b0);
    wait_valid(1'b0, lat);
    check("post_rst_res",     64'(bus.o_res), 64'h0000_0002);
    check("post_rst_cry",     64'(bus.o_cry), 64'd0);
    check("post_rst_latency", 64'(lat),       64'(WN));
    $display("post reset: res=%h cry=%0d lat=%0d", bus.o_res, bus.o_cry, lat);
    release_txn();

    // Back-to-back requests against a reference sum
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    last_cyc    = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      bus.i_num_a = ra;
      bus.i_num_b = rb;
      bus.i_cry   = rc;
      model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      lat = -1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus.o_valid === 1'b1) begin
          lat = k;
          break;
        end
      end
      if (lat < 0) check("b2b_timeout", 64'd0, 64'd1);
      check("b2b_res", 64'(bus.o_res), 64'(model[W-1:0]));
      check("b2b_cry", 64'(bus.o_cry), 64'(model[W]));
      if (i > 0) check("b2b_period", 64'(cyc - last_cyc), 64'(WN + 2));
      last_cyc = cyc;
      $display("b2b %0d: a=%h b=%h cin=%0d -> res=%h cry=%0d", i, ra, rb, rc, bus.o_res, bus.o_cry);
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/adder_xxbit_seq_ctrl.md
ADDER_XXBIT_SEQ_CTRL -- requirements
Module: adder_xxbit_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the width of one adder word and of the adder_xxbit_serial instance.
REQ-002 SHALL have parameter WORD_NUM, default 4, giving the number of words per operand; it is at least 2.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port i_valid, input, 1, request valid.
REQ-006 SHALL have port o_ready, output, 1, controller can accept a request.
REQ-007 SHALL have port i_num_a, input, DATA_WIDTH*WORD_NUM, operand a; word 0 is the least significant.
REQ-008 SHALL have port i_num_b, input, DATA_WIDTH*WORD_NUM, operand b.
REQ-009 SHALL have port i_cry, input, 1, carry into word 0.
REQ-010 SHALL have port o_valid, output, 1, result valid.
REQ-011 SHALL have port i_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port o_res, output, DATA_WIDTH*WORD_NUM, sum.
REQ-013 SHALL have port o_cry, output, 1, carry out of word WORD_NUM-1.
REQ-014 SHALL have port o_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CALC and DONE.
REQ-016 In IDLE: o_ready=1, o_valid=0; on an edge with i_valid=1, SHALL latch i_num_a, i_num_b and i_cry, clear the word index, and go to CALC.
REQ-017 While i_valid=0 in IDLE, SHALL stay in IDLE with all registers unchanged.
REQ-018 In CALC: o_ready=0; each cycle, SHALL drive word[index] of the latched a and b into the single adder_xxbit_serial instance.
REQ-019 The adder carry-in SHALL be the latched i_cry for index 0, and the registered carry of the previous word otherwise.
REQ-020 At each CALC edge, SHALL write the adder result into o_res word[index], register the adder carry, and increment the index.
REQ-021 At the CALC edge where index=WORD_NUM-1, SHALL load o_cry from the adder carry and go to DONE.
REQ-022 Latency: with the accept edge E0, word k is written at edge E(k+1); o_valid SHALL be 1 in the cycle after edge E(WORD_NUM), i.e. WORD_NUM cycles after acceptance.
REQ-023 In DONE: o_valid=1, o_ready=0, and o_res/o_cry SHALL be held stable until an edge with i_ready=1, which returns the FSM to IDLE.
REQ-024 o_res and o_cry SHALL keep their last values in IDLE until the next result overwrites them word by word.
REQ-025 Inputs SHALL be ignored outside IDLE; i_valid held high during CALC/DONE SHALL NOT start a new operation.
REQ-026 The sum SHALL be modulo 2^(DATA_WIDTH*WORD_NUM), with the wrap indicated only by o_cry.
REQ-027 No combinational path SHALL exist from i_valid or i_ready to o_ready or o_valid; both are decoded from state only.
REQ-028 The index counter SHALL be ceil(log2(WORD_NUM)) bits wide, minimum 1, and SHALL NOT wrap past WORD_NUM-1.

Reset
REQ-029 On i_rst=1, immediately and regardless of clock: state=IDLE, index=0, carry register=0, o_res=0, o_cry=0, o_valid=0, o_busy=0, o_ready=1.
REQ-030 Reset asserted in CALC or DONE SHALL abort the operation without producing o_valid; the first request after deassertion SHALL behave as from power-up.

Structure
REQ-031 The FSM state enum typedef SHALL live in the shared package adder_pkg, and this module SHALL import it.
REQ-032 The module SHALL contain exactly one sub-module: adder_xxbit_serial with DATA_WIDTH passed through; it SHALL NOT add in any other way.

Verification
REQ-033 The bench SHALL apply A=0xFFFFFFFF, B=0x00000001, cry=0 -> o_res=0x00000000, o_cry=1, with o_valid first high 4 cycles after acceptance.
REQ-034 The bench SHALL apply A=0x12345678, B=0x11111111, cry=1 -> o_res=0x2345678A, o_cry=0.
REQ-035 The bench SHALL hold i_ready=0 for 5 cycles in DONE -> o_valid, o_res and o_cry stay stable; i_ready=1 -> IDLE on the next cycle with o_ready=1.
REQ-036 The bench SHALL change i_valid/i_num_a randomly during CALC -> the result matches the operands latched at acceptance.
REQ-037 The bench SHALL assert i_rst at the second CALC cycle -> outputs are at their reset values asynchronously; the next request A=0x00000001, B=0x00000001 -> o_res=0x00000002.
REQ-038 The bench SHALL issue back-to-back requests with i_ready=1 and i_valid=1 always -> one result every WORD_NUM+2 cycles, each matching a reference model over 1000 random pairs.
